// File: rtl/quad_decoder.sv
// ============================================================================
// Module      : quad_decoder
// Description : Quadrature decoder for debounced rotary-encoder A/B channels.
//               Tracks the Gray-code phase, emits step/direction pulses, keeps
//               a signed position count and flags illegal double-bit jumps.
//               Optional index-channel clear: define QUAD_DECODER_INDEX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
    parameter int p_CNT_WIDTH = 16,
    parameter int p_X4        = 1,
    parameter int p_SATURATE  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_a,
    input  logic                   i_b,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic                   i_err_clr,
`ifdef QUAD_DECODER_INDEX_EN
    input  logic                   i_idx,
    output logic                   o_idx,
`endif
    output logic [p_CNT_WIDTH-1:0] ov_pos,
    output logic                   o_step,
    output logic                   o_dir,
    output logic                   o_err
);

    localparam logic [p_CNT_WIDTH-1:0] c_POS_MAX = {1'b0, {(p_CNT_WIDTH-1){1'b1}}};
    localparam logic [p_CNT_WIDTH-1:0] c_POS_MIN = {1'b1, {(p_CNT_WIDTH-1){1'b0}}};
    localparam logic [p_CNT_WIDTH-1:0] c_ONE     = {{(p_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [p_CNT_WIDTH-1:0] c_ZERO    = '0;

    typedef enum logic [0:0] {
        S_UNPRIMED = 1'b0,
        S_TRACK    = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               prev_q, prev_d;
    logic [p_CNT_WIDTH-1:0]   pos_q, pos_d;
    logic                     step_q, step_d;
    logic                     dir_q, dir_d;
    logic                     err_q, err_d;

    logic [1:0]               w_cur;
    logic                     w_moved;
    logic                     w_illegal;
    logic                     w_legal;
    logic                     w_up;
    logic                     w_cand;
    logic                     w_count;
    logic                     w_clr;
    logic [p_CNT_WIDTH-1:0]   w_pos_inc;
    logic [p_CNT_WIDTH-1:0]   w_pos_dec;
    logic [p_CNT_WIDTH-1:0]   w_pos_step;

`ifdef QUAD_DECODER_INDEX_EN
    logic                     idx_prev_q, idx_prev_d;
    logic                     idx_q, idx_d;
    logic                     w_idx_rise;
`endif

    // Successor phase in the clockwise direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    always_comb begin
        w_cur     = {i_a, i_b};
        state_d   = S_TRACK;
        prev_d    = w_cur;

        w_moved   = (state_q == S_TRACK) && (w_cur != prev_q);
        w_illegal = w_moved && (w_cur == ~prev_q);
        w_legal   = w_moved && !w_illegal;
        w_up      = (w_cur == next_up(prev_q));

        // In x1 mode only arrivals at detent 00 count: from 10 (up) or 01 (down).
        if (p_X4 != 0) begin
            w_cand = w_legal;
        end else begin
            w_cand = w_legal && (w_cur == 2'b00);
        end
        w_count = w_cand && i_en;

        w_pos_inc = pos_q + c_ONE;
        w_pos_dec = pos_q - c_ONE;
        if (p_SATURATE != 0 && pos_q == c_POS_MAX) begin
            w_pos_inc = c_POS_MAX;
        end
        if (p_SATURATE != 0 && pos_q == c_POS_MIN) begin
            w_pos_dec = c_POS_MIN;
        end
        w_pos_step = w_up ? w_pos_inc : w_pos_dec;

`ifdef QUAD_DECODER_INDEX_EN
        idx_prev_d = i_idx;
        w_idx_rise = i_idx && !idx_prev_q;
        idx_d      = w_idx_rise;
        w_clr      = i_clr || w_idx_rise;
`else
        w_clr      = i_clr;
`endif

        if (w_clr) begin
            pos_d = c_ZERO;
        end else if (w_count) begin
            pos_d = w_pos_step;
        end else begin
            pos_d = pos_q;
        end

        step_d = w_count;
        dir_d  = w_count ? w_up : dir_q;

        // A new illegal jump outranks a simultaneous clear request.
        if (w_illegal) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_UNPRIMED;
            prev_q     <= 2'b00;
            pos_q      <= c_ZERO;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef QUAD_DECODER_INDEX_EN
            idx_prev_q <= 1'b0;
            idx_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
`ifdef QUAD_DECODER_INDEX_EN
            idx_prev_q <= idx_prev_d;
            idx_q      <= idx_d;
`endif
        end
    end

    assign ov_pos = pos_q;
    assign o_step = step_q;
    assign o_dir  = dir_q;
    assign o_err  = err_q;
`ifdef QUAD_DECODER_INDEX_EN
    assign o_idx  = idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// Module      : tb_quad_decoder
// Description : Directed self-checking bench for quad_decoder; four instances
//               (x4, x1, 4-bit wrap, 4-bit saturate) share one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, a, b, en, clr, err_clr;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt_x4 = 0;
    int   cnt_x1 = 0;
    int   base4, base1;

    logic [15:0] pos_x4, pos_x1;
    logic [3:0]  pos_w4, pos_w4s;
    logic step_x4, dir_x4, err_x4;
    logic step_x1, dir_x1, err_x1;
    logic step_w4, dir_w4, err_w4;
    logic step_w4s, dir_w4s, err_w4s;
`ifdef QUAD_DECODER_INDEX_EN
    logic idx_x4, idx_x1, idx_w4, idx_w4s;
`endif

    quad_decoder #(.p_CNT_WIDTH(16), .p_X4(1), .p_SATURATE(0)) u_x4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en),
        .i_clr(clr), .i_err_clr(err_clr),
`ifdef QUAD_DECODER_INDEX_EN
        .i_idx(1'b0), .o_idx(idx_x4),
`endif
        .ov_pos(pos_x4), .o_step(step_x4), .o_dir(dir_x4), .o_err(err_x4));

    quad_decoder #(.p_CNT_WIDTH(16), .p_X4(0), .p_SATURATE(0)) u_x1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en),
        .i_clr(clr), .i_err_clr(err_clr),
`ifdef QUAD_DECODER_INDEX_EN
        .i_idx(1'b0), .o_idx(idx_x1),
`endif
        .ov_pos(pos_x1), .o_step(step_x1), .o_dir(dir_x1), .o_err(err_x1));

    quad_decoder #(.p_CNT_WIDTH(4), .p_X4(1), .p_SATURATE(0)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en),
        .i_clr(clr), .i_err_clr(err_clr),
`ifdef QUAD_DECODER_INDEX_EN
        .i_idx(1'b0), .o_idx(idx_w4),
`endif
        .ov_pos(pos_w4), .o_step(step_w4), .o_dir(dir_w4), .o_err(err_w4));

    quad_decoder #(.p_CNT_WIDTH(4), .p_X4(1), .p_SATURATE(1)) u_w4s (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en),
        .i_clr(clr), .i_err_clr(err_clr),
`ifdef QUAD_DECODER_INDEX_EN
        .i_idx(1'b0), .o_idx(idx_w4s),
`endif
        .ov_pos(pos_w4s), .o_step(step_w4s), .o_dir(dir_w4s), .o_err(err_w4s));

    always @(negedge clk) begin
        if (step_x4) cnt_x4++;
        if (step_x1) cnt_x1++;
    end

    task automatic drive(input logic va, input logic vb);
        @(negedge clk);
        a = va;
        b = vb;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fail(input string tag, input int obs, input int expv);
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] up_seq [4];
        up_seq[0] = 2'b01;
        up_seq[1] = 2'b11;
        up_seq[2] = 2'b10;
        up_seq[3] = 2'b00;

        rst_n = 1'b0; a = 1'b1; b = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
        idle(2);
        n_cmp++; if (pos_x4 !== 16'd0) fail("reset_pos", pos_x4, 0);
        n_cmp++; if (step_x4 !== 1'b0) fail("reset_step", step_x4, 0);
        n_cmp++; if (dir_x4 !== 1'b0) fail("reset_dir", dir_x4, 0);
        n_cmp++; if (err_x4 !== 1'b0) fail("reset_err", err_x4, 0);
        n_cmp++; if (pos_w4s !== 4'd0) fail("reset_pos_w4s", pos_w4s, 0);

        @(negedge clk) rst_n = 1'b1;
        idle(3);
        n_cmp++; if (cnt_x4 !== 0) fail("prime_no_step", cnt_x4, 0);
        n_cmp++; if (pos_x4 !== 16'd0) fail("prime_pos", pos_x4, 0);
        n_cmp++; if (err_x4 !== 1'b0) fail("prime_err", err_x4, 0);

        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        idle(1);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        n_cmp++; if (pos_x4 !== 16'd0) fail("clr_pos_x4", pos_x4, 0);
        n_cmp++; if (pos_x1 !== 16'd0) fail("clr_pos_x1", pos_x1, 0);
        idle(1);
        base4 = cnt_x4;
        base1 = cnt_x1;

        drive(1'b0, 1'b1);
        n_cmp++; if (step_x4 !== 1'b1) fail("up1_step_x4", step_x4, 1);
        n_cmp++; if (step_x1 !== 1'b0) fail("up1_step_x1", step_x1, 0);
        n_cmp++; if (pos_x4 !== 16'd1) fail("up1_pos_x4", pos_x4, 1);
        idle(3);
        n_cmp++; if (step_x4 !== 1'b0) fail("up1_step_gone", step_x4, 0);
        drive(1'b1, 1'b1); idle(3);
        drive(1'b1, 1'b0); idle(3);
        drive(1'b0, 1'b0); idle(3);
        n_cmp++; if (pos_x4 !== 16'd4) fail("up_pos_x4", pos_x4, 4);
        n_cmp++; if (dir_x4 !== 1'b1) fail("up_dir_x4", dir_x4, 1);
        n_cmp++; if (cnt_x4 - base4 !== 4) fail("up_steps_x4", cnt_x4 - base4, 4);
        n_cmp++; if (pos_x1 !== 16'd1) fail("up_pos_x1", pos_x1, 1);
        n_cmp++; if (cnt_x1 - base1 !== 1) fail("up_steps_x1", cnt_x1 - base1, 1);
        n_cmp++; if (dir_x1 !== 1'b1) fail("up_dir_x1", dir_x1, 1);

        drive(1'b1, 1'b0); idle(3);
        drive(1'b1, 1'b1); idle(3);
        drive(1'b0, 1'b1); idle(3);
        drive(1'b0, 1'b0); idle(3);
        n_cmp++; if (pos_x4 !== 16'd0) fail("dn_pos_x4", pos_x4, 0);
        n_cmp++; if (dir_x4 !== 1'b0) fail("dn_dir_x4", dir_x4, 0);
        n_cmp++; if (cnt_x4 - base4 !== 8) fail("dn_steps_x4", cnt_x4 - base4, 8);
        n_cmp++; if (pos_x1 !== 16'd0) fail("dn_pos_x1", pos_x1, 0);
        n_cmp++; if (cnt_x1 - base1 !== 2) fail("dn_steps_x1", cnt_x1 - base1, 2);
        n_cmp++; if (dir_x1 !== 1'b0) fail("dn_dir_x1", dir_x1, 0);

        drive(1'b1, 1'b1);
        n_cmp++; if (err_x4 !== 1'b1) fail("ill_err", err_x4, 1);
        n_cmp++; if (pos_x4 !== 16'd0) fail("ill_pos", pos_x4, 0);
        n_cmp++; if (step_x4 !== 1'b0) fail("ill_step", step_x4, 0);
        @(negedge clk) begin a = 1'b0; b = 1'b0; err_clr = 1'b1; end
        @(negedge clk) err_clr = 1'b0;
        n_cmp++; if (err_x4 !== 1'b1) fail("ill_set_wins", err_x4, 1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        n_cmp++; if (err_x4 !== 1'b0) fail("err_cleared", err_x4, 0);
        n_cmp++; if (pos_x4 !== 16'd0) fail("err_pos", pos_x4, 0);

        for (int i = 0; i < 7; i++) begin
            drive(up_seq[i % 4][1], up_seq[i % 4][0]);
            idle(1);
        end
        n_cmp++; if (pos_w4 !== 4'd7) fail("w4_at_max", pos_w4, 7);
        n_cmp++; if (pos_w4s !== 4'd7) fail("w4s_at_max", pos_w4s, 7);
        drive(1'b0, 1'b0);
        n_cmp++; if (pos_w4 !== 4'b1000) fail("w4_wrap_min", pos_w4, 8);
        n_cmp++; if (pos_w4s !== 4'd7) fail("w4s_hold_max", pos_w4s, 7);
        n_cmp++; if (step_w4s !== 1'b1) fail("w4s_step_clamped", step_w4s, 1);
        n_cmp++; if (pos_x4 !== 16'd8) fail("x4_pos_8", pos_x4, 8);
        idle(1);
        drive(1'b1, 1'b0);
        n_cmp++; if (pos_w4 !== 4'd7) fail("w4_wrap_max", pos_w4, 7);
        n_cmp++; if (pos_w4s !== 4'd6) fail("w4s_dec", pos_w4s, 6);
        n_cmp++; if (dir_w4 !== 1'b0) fail("w4_dir_dn", dir_w4, 0);
        idle(1);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        n_cmp++; if (pos_x4 !== 16'd0) fail("clr2_pos", pos_x4, 0);
        idle(1);

        base4 = cnt_x4;
        @(negedge clk) en = 1'b0;
        drive(1'b0, 1'b0); idle(1);
        drive(1'b0, 1'b1); idle(1);
        @(negedge clk) en = 1'b1;
        idle(2);
        n_cmp++; if (pos_x4 !== 16'd0) fail("en_pos", pos_x4, 0);
        n_cmp++; if (cnt_x4 - base4 !== 0) fail("en_no_step", cnt_x4 - base4, 0);
        n_cmp++; if (err_x4 !== 1'b0) fail("en_err", err_x4, 0);
        drive(1'b1, 1'b1);
        n_cmp++; if (pos_x4 !== 16'd1) fail("reen_pos", pos_x4, 1);
        n_cmp++; if (step_x4 !== 1'b1) fail("reen_step", step_x4, 1);
        idle(1);
        @(negedge clk) begin a = 1'b0; b = 1'b1; clr = 1'b1; end
        @(negedge clk) clr = 1'b0;
        n_cmp++; if (pos_x4 !== 16'd0) fail("clr_step_pos", pos_x4, 0);
        n_cmp++; if (step_x4 !== 1'b1) fail("clr_step_step", step_x4, 1);
        n_cmp++; if (dir_x4 !== 1'b0) fail("clr_step_dir", dir_x4, 0);
        idle(1);

        drive(1'b1, 1'b1);
        n_cmp++; if (pos_x4 !== 16'd1) fail("pre_rst_pos", pos_x4, 1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (pos_x4 !== 16'd0) fail("mid_rst_pos", pos_x4, 0);
        n_cmp++; if (dir_x4 !== 1'b0) fail("mid_rst_dir", dir_x4, 0);
        a = 1'b0; b = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (step_x4 !== 1'b0) fail("rst_prime_step", step_x4, 0);
        n_cmp++; if (err_x4 !== 1'b0) fail("rst_prime_err", err_x4, 0);
        drive(1'b0, 1'b1);
        n_cmp++; if (step_x4 !== 1'b1) fail("post_rst_step", step_x4, 1);
        n_cmp++; if (pos_x4 !== 16'd1) fail("post_rst_pos", pos_x4, 1);
        n_cmp++; if (dir_x4 !== 1'b1) fail("post_rst_dir", dir_x4, 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder for rotary encoders.
- Sits directly downstream of the switch debouncer and consumes its debounced A/B channel outputs.
- Tracks the Gray-code phase, emits one-cycle step pulses with direction, and maintains a signed position counter.
- Flags illegal double-bit transitions caused by missed phases.

Parameters:
p_CNT_WIDTH, 16, position counter width in bits, two's complement.
p_X4, 1, 1 = count every phase edge (4 counts/cycle); 0 = count once per full cycle at detent 00.
p_SATURATE, 0, 0 = position wraps around; 1 = position clamps at signed min/max.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  synchronous reset, active-low.
i_a  input  1  debounced channel A, synchronous to i_clk.
i_b  input  1  debounced channel B, synchronous to i_clk.
i_en  input  1  count enable.
i_clr  input  1  synchronous position clear.
i_err_clr  input  1  clears the sticky error flag.
ov_pos  output  p_CNT_WIDTH  signed position.
o_step  output  1  one-cycle pulse per counted step.
o_dir  output  1  direction of the last counted step; 1 = up (CW), 0 = down.
o_err  output  1  sticky illegal-transition flag.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n, sampled at posedge i_clk.
- Reset values: ov_pos = 0, o_step = 0, o_dir = 0, o_err = 0, state = UNPRIMED.
- States:
  - UNPRIMED: at the next posedge, load rv_prev <= {i_a, i_b}, no count, go to TRACK. This prevents a spurious step on the first sample.
  - TRACK: at each posedge, compare cur = {i_a, i_b} against rv_prev, then set rv_prev <= cur.
- Transition decode, as {A,B}:
  - Up sequence: 00->01->11->10->00.
  - Down sequence: the reverse.
  - cur == prev: no action.
  - Both bits changed: illegal. Set o_err, no count, no step, rv_prev still updates.
- Count rules:
  - p_X4=1: every legal transition counts +1 (up) or -1 (down).
  - p_X4=0: only 10->00 counts +1 and only 01->00 counts -1; all other legal transitions update phase only.
- Latency: the input change sampled at posedge N is reflected in ov_pos, o_step and o_dir after posedge N. o_step is high for exactly one cycle per count. o_dir updates only on counted steps.
- i_en=0: phase tracking continues and illegal transitions still set o_err, but no count and no o_step. Re-enabling therefore produces no spurious step.
- Arithmetic:
  - p_SATURATE=0: p_CNT_WIDTH-bit modular; max+1 -> min, min-1 -> max.
  - p_SATURATE=1: +1 at max holds max, -1 at min holds min. o_step still pulses when clamped.
- Priority, highest first: reset > i_clr > count.
  - i_clr with a simultaneous step: ov_pos = 0, o_step still pulses, o_dir updates.
- o_err: set by an illegal transition, cleared by i_err_clr. If both occur in the same cycle, set wins (o_err stays 1).
- Reset mid-rotation returns to UNPRIMED. The first post-reset sample never counts.

Optional Feature:
- Macro QUAD_DECODER_INDEX_EN.
- Defined:
  - Adds port i_idx (input, 1, debounced index channel) and output o_idx (1-cycle pulse).
  - On a rising edge of i_idx (registered previous value), ov_pos <= 0 and o_idx pulses.
  - A step in the same cycle is discarded from ov_pos but o_step still pulses.
  - i_clr and the index clear have equal effect. Reset sets the previous i_idx value to 0.
- Undefined: neither port exists and the behaviour is exactly as above.

Test Plan:
- Reset, hold {A,B}=11, release reset, wait 3 cycles -> no o_step, ov_pos=0, o_err=0.
- p_X4=1, drive 00,01,11,10,00 with one step per 4 clocks -> four o_step pulses, o_dir=1, ov_pos=4. Reverse sequence -> ov_pos=0, o_dir=0.
- p_X4=0, one full up cycle then one full down cycle -> ov_pos 0->1->0, exactly one o_step each way.
- From 00 jump to 11 -> o_err=1, ov_pos unchanged. Assert i_err_clr together with another illegal jump -> o_err stays 1. i_err_clr alone -> o_err=0.
- p_CNT_WIDTH=4:
  - p_SATURATE=0: from ov_pos=7, one up step -> -8.
  - p_SATURATE=1: from 7, one up step -> 7 with o_step=1.
- i_en=0 during two up steps, then i_en=1 -> ov_pos unchanged, no o_step. Next legal step counts exactly +1. Assert i_clr with a step in the same cycle -> ov_pos=0, o_step=1.
